// File: rtl/mux_3in.sv
// mux_3in: 3-to-1 word selector with a clocked illegal-select (sel = 3) flag and saturating counter.
// Build macro MUX3_OUT_REG_EN puts `out` behind a register (1-cycle latency, async clear on rst).
module mux_3in #(
  parameter int               WIDTH       = 32,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] ILLEGAL_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             sel_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       SEL_ILLEGAL = 2'd3;

  logic [WIDTH-1:0] dec_s;
  logic             illegal_s;
  logic             sel_err_r;
  logic [CNT_W-1:0] err_cnt_r;

  // Source decode; an unknown sel falls to default so X never reaches out.
  always_comb begin
    dec_s = ILLEGAL_VAL;
    case (sel)
      2'd0:    dec_s = in1;
      2'd1:    dec_s = in2;
      2'd2:    dec_s = in3;
      default: dec_s = ILLEGAL_VAL;
    endcase
  end

  assign illegal_s = (sel == SEL_ILLEGAL);

  // Sticky illegal-select flag and saturating illegal-edge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_r <= 1'b0;
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (illegal_s) begin
      sel_err_r <= 1'b1;
      if (err_cnt_r != CNT_MAX) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end else begin
      sel_err_r <= sel_err_r;
      err_cnt_r <= err_cnt_r;
    end
  end

  assign sel_err = sel_err_r;
  assign err_cnt = err_cnt_r;

`ifdef MUX3_OUT_REG_EN
  logic [WIDTH-1:0] out_r;

  // Output pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= {WIDTH{1'b0}};
    end else begin
      out_r <= dec_s;
    end
  end

  assign out = out_r;
`else
  assign out = dec_s;
`endif

endmodule

// File: tb/tb_mux_3in.sv
// tb_mux_3in: directed vectors; stimulus pushes expected results into a scoreboard queue,
// a separate monitor pops and compares one sample later.
module tb_mux_3in;

  logic        clk;
  logic        rst;
  logic [31:0] in1, in2, in3;
  logic [1:0]  sel;
  logic [31:0] out_a, out_b;
  logic        sel_err_a, sel_err_b;
  logic [7:0]  err_cnt_a;
  logic [1:0]  err_cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          chk_out;
    logic [31:0] exp_out;
    bit          chk_flags;
    logic        exp_err;
    logic [7:0]  exp_cnt;
    logic [1:0]  exp_cnt2;
  } exp_t;

  exp_t sb[$];
  event chk_ev;

  mux_3in #(.WIDTH(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .sel(sel),
    .out(out_a), .sel_err(sel_err_a), .err_cnt(err_cnt_a)
  );

  mux_3in #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3), .sel(sel),
    .out(out_b), .sel_err(sel_err_b), .err_cnt(err_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 50000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Push expectation; the monitor samples one time unit later.
  task automatic expect_chk(input string n, input bit co, input logic [31:0] eo,
                            input bit cf, input logic ee, input logic [7:0] ec,
                            input logic [1:0] ec2);
    exp_t e;
    e.name = n; e.chk_out = co; e.exp_out = eo;
    e.chk_flags = cf; e.exp_err = ee; e.exp_cnt = ec; e.exp_cnt2 = ec2;
    sb.push_back(e);
    -> chk_ev;
    #2;
  endtask

  task automatic expect_out(input string n, input logic [31:0] eo);
    expect_chk(n, 1'b1, eo, 1'b0, 1'b0, 8'd0, 2'd0);
  endtask

  task automatic expect_flags(input string n, input logic ee, input logic [7:0] ec,
                              input logic [1:0] ec2);
    expect_chk(n, 1'b0, 32'd0, 1'b1, ee, ec, ec2);
  endtask

  // Monitor: pops one expectation per request and compares both instances.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: sample requested with empty scoreboard at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.chk_out) begin
          cmp({e.name, ".out"}, out_a, e.exp_out);
          cmp({e.name, ".out_b"}, out_b, e.exp_out);
        end
        if (e.chk_flags) begin
          cmp({e.name, ".sel_err"}, {31'd0, sel_err_a}, {31'd0, e.exp_err});
          cmp({e.name, ".err_cnt"}, {24'd0, err_cnt_a}, {24'd0, e.exp_cnt});
          cmp({e.name, ".sel_err_b"}, {31'd0, sel_err_b}, {31'd0, e.exp_err});
          cmp({e.name, ".err_cnt_b"}, {30'd0, err_cnt_b}, {30'd0, e.exp_cnt2});
        end
      end
    end
  end

  logic [1:0]  sw_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] sw_exp [5] = '{32'd0, 32'd700, 32'd128, 32'd0, 32'd0};

  initial begin
    rst = 1'b1; sel = 2'd0;
    in1 = 32'd0; in2 = 32'd0; in3 = 32'd0;
    #2;
    expect_chk("reset", 1'b1, 32'd0, 1'b1, 1'b0, 8'd0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef MUX3_OUT_REG_EN
    @(negedge clk);
    sel = 2'd1; in2 = 32'd700;
    expect_out("reg_before_edge", 32'd0);
    @(posedge clk);
    expect_out("reg_after_edge", 32'd700);
    @(negedge clk);
    rst = 1'b1;
    expect_out("reg_async_rst", 32'd0);
    rst = 1'b0;
    sel = 2'd0;
`else
    // Sweep with 5-unit steps; sel=3 is never present at a rising edge.
    @(negedge clk);
    #1;
    in1 = 32'd0; in2 = 32'd700; in3 = 32'd128;
    for (int i = 0; i < 5; i++) begin
      sel = sw_sel[i];
      expect_out($sformatf("sweep%0d", i), sw_exp[i]);
      #3;
    end
    expect_flags("sweep_no_edge", 1'b0, 8'd0, 2'd0);
    #3;
    in1 = 32'hFFFF_FFFF; in2 = 32'h8000_0001; in3 = 32'h0000_0000;
    sel = 2'd0; expect_out("pass_in1", 32'hFFFF_FFFF); #3;
    sel = 2'd1; expect_out("pass_in2", 32'h8000_0001); #3;
    sel = 2'd2; expect_out("pass_in3", 32'h0000_0000); #3;
    sel = 2'd0; in1 = 32'h1234_5678;
    expect_out("data_change", 32'h1234_5678); #3;
    sel = 2'd2; in3 = 32'hA5A5_5A5A;
    expect_out("data_change3", 32'hA5A5_5A5A); #3;
    sel = 2'd3;
    expect_out("illegal_out", 32'd0); #3;
`endif

    // Five illegal edges: 8-bit counter reads 5, 2-bit counter saturates at 3.
    @(negedge clk);
    sel = 2'd0; rst = 1'b1;
    #1;
    rst = 1'b0; sel = 2'd3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    expect_flags("illegal5", 1'b1, 8'd5, 2'd3);
    sel = 2'd0;
`ifndef MUX3_OUT_REG_EN
    expect_out("wrap_to_in1", 32'h1234_5678);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_flags("hold_after_illegal", 1'b1, 8'd5, 2'd3);
    sel = 2'd3;
    @(posedge clk);
    @(negedge clk);
    sel = 2'd0;
    expect_flags("saturate6", 1'b1, 8'd6, 2'd3);

    // Four illegal edges, then async reset between edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0; sel = 2'd3;
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_flags("count4", 1'b1, 8'd4, 2'd3);
    rst = 1'b1;
    expect_chk("async_rst", 1'b1, 32'd0, 1'b1, 1'b0, 8'd0, 2'd0);
`ifndef MUX3_OUT_REG_EN
    sel = 2'd1; in2 = 32'd700;
    expect_out("out_ignores_rst", 32'd700);
`endif
    sel = 2'd3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_flags("rst_wins_edge", 1'b0, 8'd0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    sel = 2'd0;
    expect_flags("resume_count", 1'b1, 8'd1, 2'd1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
